scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Parametrised pixel-scan engine for the speckle sensor array, the successor to the fixed 24×24 scan inside `speckle_sensor_controller`. It drives the chip's row and column token shift registers at a programmable divided rate and triggers the XADC once per sample. It averages a power-of-two number of conversions per pixel, thresholds each average into a key bit, and writes both to frame RAM. It adds scan modes: full frame, single row, ROI window and continuous. It also adds an ADC timeout and error reporting.

## Interface
- `COLS`, 24: array columns.
- `ROWS`, 24: array rows.
- `NB_DATA`, 12: ADC sample width.
- `N_AVG`, 1: conversions averaged per pixel; must be a power of two, 1..16.
- `NB_DIV`, 24: clock-divider width.
- `ADC_TIMEOUT`, 1024: clk cycles allowed between trigger and `i_adc_done`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle start pulse; ignored while `o_busy`.
- `i_stop` in 1: finishes the current frame, then leaves continuous mode.
- `i_mode` in 2: 0 full, 1 single row, 2 ROI, 3 continuous full; latched at start.
- `i_row_sel` in clog2(ROWS): row scanned in mode 1.
- `i_col_lo`, `i_col_hi` in clog2(COLS): inclusive ROI columns.
- `i_row_lo`, `i_row_hi` in clog2(ROWS): inclusive ROI rows.
- `i_clk_div` in NB_DIV: tick period is `i_clk_div`+1 cycles; latched at start.
- `i_umbral` in NB_DATA: key threshold.
- `i_adc_val` in NB_DATA: conversion result.
- `i_adc_done` in 1: end-of-conversion pulse.
- `o_adc_trigger` out 1: one-cycle conversion start.
- `o_row_clk`, `o_row_rst`, `o_row_data`, `o_row_ena` out 1: row shift register.
- `o_col_clk`, `o_col_rst`, `o_col_data` out 1: column shift register.
- `o_key_wren` out 1: key write enable to the chip, mirroring the key bit on store.
- `o_ram_wren` out 1: RAM write strobe.
- `o_ram_addr` out clog2(ROWS*COLS): RAM address, `row*COLS+col`.
- `o_ram_data` out NB_DATA: averaged pixel value.
- `o_key` out 1: key bit, 1 when average ≥ `i_umbral`.
- `o_busy` out 1: frame in progress.
- `o_frame_done` out 1: one-cycle pulse at the end of each frame.
- `o_err` out 1: sticky error flag; cleared by reset or by an accepted `i_start`.

## Operation
- Tick: a divider counter generates a one-cycle `tick` when it reaches `i_clk_div`. All chip-pin state changes occur on ticks.
- Shift clocks: each shift takes 2 ticks, clock high for the first tick and low for the second. Data is stable for the whole shift.
- States:
  - IDLE → SR_RST on accepted start.
  - SR_RST: assert `o_row_rst` and `o_col_rst` for 2 ticks, then go to ROW_INJ.
  - ROW_INJ: shift in a 1 with `o_row_data`=1, making row 0 active.
  - ROW_SKIP: shift once per row below the first scanned row.
  - COL_INJ: inject the column token the same way.
  - COL_SKIP: shift columns below the first scanned column.
  - SETTLE: 1 tick with `o_row_ena`=1.
  - CONV: pulse `o_adc_trigger`, then go to WAIT.
  - WAIT: on `i_adc_done`, add `i_adc_val` to the accumulator. If the sample count is below N_AVG go to CONV, else go to STORE.
  - STORE: 1 cycle. Assert `o_ram_wren` with `o_ram_data` = sum >> log2(N_AVG) (accumulator is NB_DATA+4 bits) and the key bit.
  - COL_NEXT: shift the column. After the last scanned column, go to ROW_NEXT. The remaining columns are not shifted; the next COL_INJ begins with a column reset.
  - ROW_NEXT: pulse `o_col_rst`, shift the row, then go to COL_INJ or DONE.
  - DONE: pulse `o_frame_done`. Go to SR_RST if in mode 3 and no stop is pending, otherwise go to IDLE.
- Mode 1 scans row `i_row_sel` across all columns. Mode 2 scans the inclusive window. Modes 0 and 3 scan everything.
- Timeout: if WAIT lasts ADC_TIMEOUT cycles, set `o_err`, treat the sample as 0 and continue.
- Invalid window: ROI lo > hi, or `i_row_sel` ≥ ROWS, sets `o_err` and goes directly to DONE, so `o_frame_done` still pulses.
- `i_stop` in IDLE has no effect. In modes 0–2 it has no effect.
- An `i_adc_done` that arrives outside WAIT is ignored.

## Timing
- All outputs are 0 in reset and on the cycle after `i_rst`. Reset mid-frame returns to IDLE; no RAM write completes.
- `o_busy` rises the cycle after an accepted `i_start` and falls in the cycle after DONE.
- `o_adc_trigger` rises exactly 1 cycle after CONV entry and is high for 1 cycle.
- STORE follows the final `i_adc_done` by 1 cycle.
- `o_ram_addr`, `o_ram_data` and `o_key` are valid only while `o_ram_wren`=1.
- With `i_clk_div`=0, a tick occurs every cycle.

## Structure
- Shared package `ssc_pkg` holds:
  - the state enum;
  - mode constants `MODE_FULL`, `MODE_ROW`, `MODE_ROI`, `MODE_CONT`;
  - the address width function.
- Sub-module `tick_gen`: the divider with synchronous reset and a load-at-start input.
- `speckle_sensor_controller` instantiates `scan_sequencer` in place of its internal scan.

## Test plan
- Full frame: ROWS=COLS=4, div=0, N_AVG=1, ADC model returns `addr*10` → 16 writes, addresses 0..15 in order, data `addr*10`, key correct for umbral 75, and exactly one `o_frame_done`.
- ROI cols 1..2, rows 2..3, N_AVG=4, samples 100,101,102,103 → 4 writes at addresses 9,10,13,14, each with data 101.
- Timeout: ADC never responds on pixel 5 → `o_err`=1, RAM data 0 at address 5, and the frame completes.
- Continuous mode with `i_stop` mid-frame 2 → frame 2 completes, 2 `o_frame_done` pulses in total, then IDLE.
- `i_clk_div`=3 → `o_row_clk` high for 4 cycles and low for 4 cycles.
- Reset during WAIT → all outputs 0 next cycle; a start accepted afterwards scans normally.
- ROI lo > hi → `o_err`=1 and `o_frame_done` pulses with zero writes.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and helpers for the speckle pixel-scan sequencer.
package ssc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SR_RST,
    ST_ROW_INJ,
    ST_ROW_SKIP,
    ST_COL_INJ,
    ST_COL_SKIP,
    ST_SETTLE,
    ST_CONV,
    ST_WAIT,
    ST_STORE,
    ST_COL_NEXT,
    ST_ROW_NEXT,
    ST_DONE
  } ssc_state_e;

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_ROW  = 2'd1;
  localparam logic [1:0] MODE_ROI  = 2'd2;
  localparam logic [1:0] MODE_CONT = 2'd3;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the frame RAM address (row*COLS+col).
  function automatic int addr_w(input int rows, input int cols);
    return clog2_min1(rows * cols);
  endfunction

endpackage

// File: rtl/scan_sequencer_tick_gen.sv
// Programmable divider: one-cycle tick every div+1 cycles.
module tick_gen #(
  parameter int NB_DIV = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [NB_DIV-1:0] div,
  output logic              tick
);

  logic [NB_DIV-1:0] div_q;
  logic [NB_DIV-1:0] cnt;

  assign tick = (cnt == div_q);

  // Divider counter; load latches the period, clr realigns the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Pixel-scan engine: drives row/column token shift registers, averages
// ADC conversions per pixel, thresholds into a key bit and writes frame RAM.
module scan_sequencer
  import ssc_pkg::*;
#(
  parameter int COLS        = 24,
  parameter int ROWS        = 24,
  parameter int NB_DATA     = 12,
  parameter int N_AVG       = 1,
  parameter int NB_DIV      = 24,
  parameter int ADC_TIMEOUT = 1024,
  localparam int CW = clog2_min1(COLS),
  localparam int RW = clog2_min1(ROWS),
  localparam int AW = addr_w(ROWS, COLS)
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [1:0]         i_mode,
  input  logic [RW-1:0]      i_row_sel,
  input  logic [CW-1:0]      i_col_lo,
  input  logic [CW-1:0]      i_col_hi,
  input  logic [RW-1:0]      i_row_lo,
  input  logic [RW-1:0]      i_row_hi,
  input  logic [NB_DIV-1:0]  i_clk_div,
  input  logic [NB_DATA-1:0] i_umbral,
  input  logic [NB_DATA-1:0] i_adc_val,
  input  logic               i_adc_done,
  output logic               o_adc_trigger,
  output logic               o_row_clk,
  output logic               o_row_rst,
  output logic               o_row_data,
  output logic               o_row_ena,
  output logic               o_col_clk,
  output logic               o_col_rst,
  output logic               o_col_data,
  output logic               o_key_wren,
  output logic               o_ram_wren,
  output logic [AW-1:0]      o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_data,
  output logic               o_key,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_err
);

  localparam int ACC_W  = NB_DATA + 4;
  localparam int AVG_SH = $clog2(N_AVG);
  localparam int WW     = clog2_min1(ADC_TIMEOUT + 1);

  ssc_state_e state, state_n;
  logic              ph;
  logic [1:0]        mode_q;
  logic [RW-1:0]     row_first, row_last, cur_row;
  logic [CW-1:0]     col_first, col_last, cur_col;
  logic [4:0]        scnt;
  logic [WW-1:0]     wcnt;
  logic [ACC_W-1:0]  acc;
  logic              err_q, stop_pend, trig_q;
  logic              tick, shift_done, shifting, col_last_hit, tmo, start_ok, inv;
  logic [AW-1:0]     pix_addr;
  logic [NB_DATA-1:0] avg;

  // Averaged pixel: accumulator scaled down by the power-of-two sample count.
  function automatic logic [NB_DATA-1:0] avg_of(input logic [ACC_W-1:0] sum);
    return NB_DATA'(sum >> AVG_SH);
  endfunction

  tick_gen #(.NB_DIV(NB_DIV)) u_tick (
    .clk  (clk),
    .rst  (i_rst),
    .load (start_ok),
    .clr  ((state == ST_STORE) || (state == ST_DONE)),
    .div  (i_clk_div),
    .tick (tick)
  );

  assign start_ok     = (state == ST_IDLE) && i_start;
  assign inv          = ((i_mode == MODE_ROW) && (int'(i_row_sel) >= ROWS)) ||
                        ((i_mode == MODE_ROI) && ((i_col_lo > i_col_hi) || (i_row_lo > i_row_hi) ||
                         (int'(i_col_hi) >= COLS) || (int'(i_row_hi) >= ROWS)));
  assign col_last_hit = (cur_col == col_last);
  assign shift_done   = tick && ph;
  assign tmo          = (wcnt == WW'(ADC_TIMEOUT - 1));
  assign pix_addr     = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
  assign avg          = avg_of(acc);
  assign shifting     = (state == ST_SR_RST) || (state == ST_ROW_INJ) || (state == ST_ROW_SKIP) ||
                        (state == ST_COL_INJ) || (state == ST_COL_SKIP) || (state == ST_ROW_NEXT) ||
                        ((state == ST_COL_NEXT) && !col_last_hit);

  // Next-state decode and chip-pin / RAM outputs from the current state.
  always_comb begin
    state_n      = state;
    o_row_clk    = 1'b0;
    o_row_rst    = 1'b0;
    o_row_data   = 1'b0;
    o_row_ena    = 1'b0;
    o_col_clk    = 1'b0;
    o_col_rst    = 1'b0;
    o_col_data   = 1'b0;
    o_ram_wren   = 1'b0;
    o_ram_addr   = '0;
    o_ram_data   = '0;
    o_key        = 1'b0;
    o_frame_done = 1'b0;
    case (state)
      ST_IDLE:     if (i_start) state_n = inv ? ST_DONE : ST_SR_RST;
      ST_SR_RST: begin
        o_row_rst = 1'b1;
        o_col_rst = 1'b1;
        if (shift_done) state_n = ST_ROW_INJ;
      end
      ST_ROW_INJ: begin
        o_row_data = 1'b1;
        o_row_clk  = !ph;
        if (shift_done) state_n = (row_first == '0) ? ST_COL_INJ : ST_ROW_SKIP;
      end
      ST_ROW_SKIP: begin
        o_row_clk = !ph;
        if (shift_done && (cur_row + RW'(1) == row_first)) state_n = ST_COL_INJ;
      end
      ST_COL_INJ: begin
        o_col_data = 1'b1;
        o_col_clk  = !ph;
        if (shift_done) state_n = (col_first == '0) ? ST_SETTLE : ST_COL_SKIP;
      end
      ST_COL_SKIP: begin
        o_col_clk = !ph;
        if (shift_done && (cur_col + CW'(1) == col_first)) state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        o_row_ena = 1'b1;
        if (tick) state_n = ST_CONV;
      end
      ST_CONV: begin
        o_row_ena = 1'b1;
        state_n   = ST_WAIT;
      end
      ST_WAIT: begin
        o_row_ena = 1'b1;
        if (i_adc_done || tmo) state_n = (int'(scnt) + 1 < N_AVG) ? ST_CONV : ST_STORE;
      end
      ST_STORE: begin
        o_row_ena  = 1'b1;
        o_ram_wren = 1'b1;
        o_ram_addr = pix_addr;
        o_ram_data = avg;
        o_key      = (avg >= i_umbral);
        state_n    = ST_COL_NEXT;
      end
      ST_COL_NEXT: begin
        if (col_last_hit) begin
          if (tick) state_n = ST_ROW_NEXT;
        end else begin
          o_col_clk = !ph;
          if (shift_done) state_n = ST_SETTLE;
        end
      end
      ST_ROW_NEXT: begin
        o_col_rst = !ph;
        o_row_clk = !ph;
        if (shift_done) state_n = (cur_row == row_last) ? ST_DONE : ST_COL_INJ;
      end
      ST_DONE: begin
        o_frame_done = 1'b1;
        state_n      = ((mode_q == MODE_CONT) && !stop_pend) ? ST_SR_RST : ST_IDLE;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  assign o_key_wren    = o_key;
  assign o_busy        = (state != ST_IDLE);
  assign o_err         = err_q;
  assign o_adc_trigger = trig_q;

  // Control state: FSM register, shift phase, scan position, sample/timeout counters.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ph        <= 1'b0;
      mode_q    <= MODE_FULL;
      row_first <= '0;
      row_last  <= '0;
      col_first <= '0;
      col_last  <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      scnt      <= '0;
      wcnt      <= '0;
      err_q     <= 1'b0;
      stop_pend <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state  <= state_n;
      trig_q <= (state == ST_CONV);
      if (state_n != state) ph <= 1'b0;
      else if (tick && shifting) ph <= !ph;
      if (start_ok) begin
        err_q     <= inv;
        stop_pend <= 1'b0;
        mode_q    <= i_mode;
        case (i_mode)
          MODE_ROW: begin
            row_first <= i_row_sel;     row_last <= i_row_sel;
            col_first <= '0;            col_last <= CW'(COLS - 1);
          end
          MODE_ROI: begin
            row_first <= i_row_lo;      row_last <= i_row_hi;
            col_first <= i_col_lo;      col_last <= i_col_hi;
          end
          default: begin
            row_first <= '0;            row_last <= RW'(ROWS - 1);
            col_first <= '0;            col_last <= CW'(COLS - 1);
          end
        endcase
      end
      if (o_busy && i_stop && (mode_q == MODE_CONT)) stop_pend <= 1'b1;
      if (shift_done) begin
        case (state)
          ST_ROW_INJ:  cur_row <= '0;
          ST_ROW_SKIP: cur_row <= cur_row + RW'(1);
          ST_ROW_NEXT: if (cur_row != row_last) cur_row <= cur_row + RW'(1);
          ST_COL_INJ:  cur_col <= '0;
          ST_COL_SKIP: cur_col <= cur_col + CW'(1);
          ST_COL_NEXT: cur_col <= cur_col + CW'(1);
          default:     ;
        endcase
      end
      if (state == ST_SETTLE) scnt <= '0;
      if (state == ST_CONV) wcnt <= '0;
      if (state == ST_WAIT) begin
        wcnt <= wcnt + WW'(1);
        if (i_adc_done || tmo) scnt <= scnt + 5'd1;
        if (tmo && !i_adc_done) err_q <= 1'b1;
      end
    end
  end

  // Sample accumulator: cleared per pixel, a timed-out sample adds nothing.
  always_ff @(posedge clk) begin
    if (state == ST_SETTLE) acc <= '0;
    else if ((state == ST_WAIT) && i_adc_done) acc <= acc + ACC_W'(i_adc_val);
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench: two 4x4 instances (1 and 4 samples per pixel) sharing stimulus.
module tb_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = '0, row_sel = '0, col_lo = '0, col_hi = '0, row_lo = '0, row_hi = '0;
  logic [7:0] clk_div = '0;
  logic [11:0] umbral = '0;

  logic [11:0] adc_val1 = '0, adc_val4 = '0;
  logic        adc_done1 = 1'b0, adc_done4 = 1'b0;

  logic trig1, row_clk1, row_rst1, row_data1, row_ena1, col_clk1, col_rst1, col_data1;
  logic key_wren1, ram_wren1, key1, busy1, fd_o1, err1;
  logic [3:0] ram_addr1;
  logic [11:0] ram_data1;
  logic trig4, row_clk4, row_rst4, row_data4, row_ena4, col_clk4, col_rst4, col_data4;
  logic key_wren4, ram_wren4, key4, busy4, fd_o4, err4;
  logic [3:0] ram_addr4;
  logic [11:0] ram_data4;

  scan_sequencer #(.COLS(4), .ROWS(4), .NB_DATA(12), .N_AVG(1), .NB_DIV(8), .ADC_TIMEOUT(20)) dut1 (
    .clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode), .i_row_sel(row_sel),
    .i_col_lo(col_lo), .i_col_hi(col_hi), .i_row_lo(row_lo), .i_row_hi(row_hi), .i_clk_div(clk_div),
    .i_umbral(umbral), .i_adc_val(adc_val1), .i_adc_done(adc_done1), .o_adc_trigger(trig1),
    .o_row_clk(row_clk1), .o_row_rst(row_rst1), .o_row_data(row_data1), .o_row_ena(row_ena1),
    .o_col_clk(col_clk1), .o_col_rst(col_rst1), .o_col_data(col_data1), .o_key_wren(key_wren1),
    .o_ram_wren(ram_wren1), .o_ram_addr(ram_addr1), .o_ram_data(ram_data1), .o_key(key1),
    .o_busy(busy1), .o_frame_done(fd_o1), .o_err(err1));

  scan_sequencer #(.COLS(4), .ROWS(4), .NB_DATA(12), .N_AVG(4), .NB_DIV(8), .ADC_TIMEOUT(20)) dut4 (
    .clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode), .i_row_sel(row_sel),
    .i_col_lo(col_lo), .i_col_hi(col_hi), .i_row_lo(row_lo), .i_row_hi(row_hi), .i_clk_div(clk_div),
    .i_umbral(umbral), .i_adc_val(adc_val4), .i_adc_done(adc_done4), .o_adc_trigger(trig4),
    .o_row_clk(row_clk4), .o_row_rst(row_rst4), .o_row_data(row_data4), .o_row_ena(row_ena4),
    .o_col_clk(col_clk4), .o_col_rst(col_rst4), .o_col_data(col_data4), .o_key_wren(key_wren4),
    .o_ram_wren(ram_wren4), .o_ram_addr(ram_addr4), .o_ram_data(ram_data4), .o_key(key4),
    .o_busy(busy4), .o_frame_done(fd_o4), .o_err(err4));

  logic [31:0] outs1, outs4;
  assign outs1 = {2'b0, trig1, row_clk1, row_rst1, row_data1, row_ena1, col_clk1, col_rst1, col_data1,
                  key_wren1, ram_wren1, ram_addr1, ram_data1, key1, busy1, fd_o1, err1};
  assign outs4 = {2'b0, trig4, row_clk4, row_rst4, row_data4, row_ena4, col_clk4, col_rst4, col_data4,
                  key_wren4, ram_wren4, ram_addr4, ram_data4, key4, busy4, fd_o4, err4};

  int n_chk = 0, n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write / frame-done monitors, sampled on the falling edge.
  int wr_addr1[64], wr_data1[64], wr_key1[64], wr_addr4[64], wr_data4[64];
  int wr1 = 0, fd1 = 0, wr4 = 0, fd4 = 0;
  always @(negedge clk) begin
    if (ram_wren1) begin
      if (wr1 < 64) begin wr_addr1[wr1] = ram_addr1; wr_data1[wr1] = ram_data1; wr_key1[wr1] = key1; end
      wr1++;
    end
    if (ram_wren4) begin
      if (wr4 < 64) begin wr_addr4[wr4] = ram_addr4; wr_data4[wr4] = ram_data4; end
      wr4++;
    end
    if (fd_o1) fd1++;
    if (fd_o4) fd4++;
  end

  // ADC models: answer each trigger two cycles later; dut1 returns index*10,
  // dut4 cycles 100..103; one dut1 trigger index can be left unanswered.
  int tcnt1 = 0, dly1 = 0, val1 = 0, drop1 = -1;
  int tcnt4 = 0, dly4 = 0, val4 = 0;
  always @(negedge clk) begin
    adc_done1 = 1'b0;
    if (dly1 > 0) begin
      dly1--;
      if (dly1 == 0) begin adc_done1 = 1'b1; adc_val1 = 12'(val1); end
    end
    if (trig1) begin
      if (tcnt1 != drop1) begin dly1 = 2; val1 = tcnt1 * 10; end
      tcnt1++;
    end
    adc_done4 = 1'b0;
    if (dly4 > 0) begin
      dly4--;
      if (dly4 == 0) begin adc_done4 = 1'b1; adc_val4 = 12'(val4); end
    end
    if (trig4) begin
      dly4 = 2; val4 = 100 + (tcnt4 % 4);
      tcnt4++;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    wr1 = 0; fd1 = 0; wr4 = 0; fd4 = 0;
    tcnt1 = 0; tcnt4 = 0; dly1 = 0; dly4 = 0;
  endtask

  task automatic set_cfg(input int m, input int rs, input int cl, input int ch, input int rl,
                         input int rh, input int dv, input int um);
    mode = 2'(m); row_sel = 2'(rs); col_lo = 2'(cl); col_hi = 2'(ch);
    row_lo = 2'(rl); row_hi = 2'(rh); clk_div = 8'(dv); umbral = 12'(um);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy1 || busy4) && n < budget) begin @(negedge clk); n++; end
    if (busy1 || busy4) check_val(tag, 1, 0);
  endtask

  int n;
  int exp_roi[4] = '{9, 10, 13, 14};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_val("reset_outs1", outs1, 0);
    check_val("reset_outs4", outs4, 0);
    rst = 1'b0;

    // full frame, threshold 75
    set_cfg(0, 0, 0, 3, 0, 3, 0, 75);
    clear_mon(); pulse_start(); wait_idle("full_timeout", 3000);
    check_val("full_writes", wr1, 16);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("full_addr%0d", k), wr_addr1[k], k);
      check_val($sformatf("full_data%0d", k), wr_data1[k], k * 10);
      check_val($sformatf("full_key%0d", k), wr_key1[k], (k * 10 >= 75) ? 1 : 0);
    end
    check_val("full_done", fd1, 1);
    check_val("full_err", err1, 0);

    // ROI cols 1..2, rows 2..3, four-sample average
    set_cfg(2, 0, 1, 2, 2, 3, 0, 75);
    clear_mon(); pulse_start(); wait_idle("roi_timeout", 3000);
    check_val("roi_writes", wr4, 4);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("roi_addr%0d", k), wr_addr4[k], exp_roi[k]);
      check_val($sformatf("roi_data%0d", k), wr_data4[k], 101);
    end
    check_val("roi_done", fd4, 1);

    // ADC timeout on pixel 5
    set_cfg(0, 0, 0, 3, 0, 3, 0, 75);
    clear_mon(); drop1 = 5; pulse_start(); wait_idle("tmo_timeout", 3000);
    drop1 = -1;
    check_val("tmo_err", err1, 1);
    check_val("tmo_writes", wr1, 16);
    check_val("tmo_addr5", wr_addr1[5], 5);
    check_val("tmo_data5", wr_data1[5], 0);
    check_val("tmo_data6", wr_data1[6], 60);
    check_val("tmo_done", fd1, 1);

    // continuous mode, stop during frame 2
    set_cfg(3, 0, 0, 3, 0, 3, 0, 75);
    clear_mon(); pulse_start();
    n = 0;
    while (fd1 < 1 && n < 3000) begin @(negedge clk); n++; end
    check_val("cont_first_frame", fd1, 1);
    repeat (20) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_idle("cont_timeout", 5000);
    check_val("cont_done", fd1, 2);
    check_val("cont_writes", wr1, 32);
    check_val("cont_err", err1, 0);
    check_val("cont_busy", busy1, 0);

    // divided shift clocks
    set_cfg(0, 0, 0, 3, 0, 3, 3, 75);
    clear_mon(); pulse_start();
    n = 0;
    while (!row_clk1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (row_clk1 && n < 50) begin n++; @(negedge clk); end
    check_val("row_clk_hi", n, 4);
    n = 0;
    while (!col_clk1 && n < 50) begin n++; @(negedge clk); end
    check_val("row_clk_lo", n, 4);
    n = 0;
    while (col_clk1 && n < 50) begin n++; @(negedge clk); end
    check_val("col_clk_hi", n, 4);
    wait_idle("div_timeout", 12000);
    check_val("div_writes", wr1, 16);

    // reset while waiting on the ADC, then a normal scan
    set_cfg(0, 0, 0, 3, 0, 3, 0, 75);
    clear_mon(); pulse_start();
    n = 0;
    while (!trig1 && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_wait_outs1", outs1, 0);
    check_val("rst_wait_outs4", outs4, 0);
    rst = 1'b0;
    clear_mon(); pulse_start(); wait_idle("rst_timeout", 3000);
    check_val("rst_writes", wr1, 16);
    check_val("rst_addr15", wr_addr1[15], 15);
    check_val("rst_data15", wr_data1[15], 150);
    check_val("rst_done", fd1, 1);

    // invalid ROI window
    set_cfg(2, 0, 3, 1, 0, 3, 0, 75);
    clear_mon(); pulse_start(); wait_idle("inv_timeout", 100);
    check_val("inv_err1", err1, 1);
    check_val("inv_err4", err4, 1);
    check_val("inv_done", fd1, 1);
    check_val("inv_writes", wr1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
